// File: rtl/rs_scheduler.sv
// rs_scheduler: allocates reservation-station slots to Issue and dispatches the oldest operand-ready slot to the ALU.
// Latency: allocation (rs_dest/rs_full) is combinational; ready in cycle t gives fu_valid in t+1.
// Backpressure: fu_ready low holds fu_data/fu_src and suppresses consumed_bus; rs_full stalls Issue.
package rs_pkg;

    typedef enum logic [3:0] {
        NOP    = 4'd0,
        ADD    = 4'd1,
        SUB    = 4'd2,
        AND_OP = 4'd3,
        OR_OP  = 4'd4,
        XOR_OP = 4'd5,
        SLL    = 4'd6,
        SRL    = 4'd7,
        SRA    = 4'd8,
        SLT    = 4'd9
    } alu_op_t;

    typedef enum logic [2:0] {
        NB   = 3'd0,
        BEQ  = 3'd1,
        BNE  = 3'd2,
        BLT  = 3'd3,
        BGE  = 3'd4,
        JAL  = 3'd5,
        JALR = 3'd6
    } branch_t;

    typedef struct packed {
        logic        valid_operands;
        alu_op_t     ALU_op;
        logic [5:0]  ROB_entry;
        branch_t     branch_type;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        load;
    } rs_out_t;

endpackage

module rs_scheduler
    import rs_pkg::*;
#(
    parameter int         NUM_RS    = 4,
    parameter logic [2:0] NONE_DEST = 3'b100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mispredicted,
    input  logic              issue_valid,
    input  logic              issue_stall,
    input  logic [NUM_RS-1:0] busy_bus,
    input  rs_out_t           rs0_data,
    input  rs_out_t           rs1_data,
    input  rs_out_t           rs2_data,
    input  rs_out_t           rs3_data,
    input  logic              fu_ready,
    output logic [2:0]        rs_dest,
    output logic              rs_full,
    output logic [NUM_RS-1:0] consumed_bus,
    output logic              fu_valid,
    output rs_out_t           fu_data,
    output logic [1:0]        fu_src,
    output logic [31:0]       dispatch_count
);

    localparam rs_out_t FU_DATA_RST = '{
        valid_operands: 1'b0,
        ALU_op:         NOP,
        ROB_entry:      6'd0,
        branch_type:    NB,
        rs1:            32'd0,
        rs2:            32'd0,
        load:           1'b0
    };

    rs_out_t           slot_data [NUM_RS];
    logic [NUM_RS-1:0] older     [NUM_RS];  // older[i][j]: slot i was allocated before slot j
    logic [NUM_RS-1:0] free;
    logic [NUM_RS-1:0] ready;
    logic [NUM_RS-1:0] win_vec;
    logic [NUM_RS-1:0] cand;
    logic [NUM_RS-1:0] win_oh;
    logic [1:0]        win_idx;
    logic [1:0]        alloc_idx;
    logic              any_free;
    logic              any_ready;
    logic              alloc;
    logic              load;

    assign slot_data[0] = rs0_data;
    assign slot_data[1] = rs1_data;
    assign slot_data[2] = rs2_data;
    assign slot_data[3] = rs3_data;

    assign free     = ~busy_bus;
    assign any_free = |free;
    assign rs_full  = issue_valid & ~any_free;
    assign alloc    = issue_valid & ~issue_stall & ~rs_full & ~mispredicted;

    always_comb begin
        alloc_idx = 2'd0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (free[i]) alloc_idx = 2'(i);
        end
    end

    assign rs_dest = (reset | mispredicted | ~any_free) ? NONE_DEST : {1'b0, alloc_idx};

    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            ready[i] = busy_bus[i] & slot_data[i].valid_operands;
        end
    end

    // A ready slot wins when no other ready slot is older than it.
    always_comb begin
        win_vec = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            win_vec[i] = ready[i];
            for (int j = 0; j < NUM_RS; j++) begin
                if (j != i && ready[j] && older[j][i]) win_vec[i] = 1'b0;
            end
        end
    end

    // Fall back to the lowest ready slot so a corrupted age order can never stall dispatch.
    assign cand      = (|win_vec) ? win_vec : ready;
    assign any_ready = |ready;

    always_comb begin
        win_idx = 2'd0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (cand[i]) win_idx = 2'(i);
        end
    end

    assign load         = (~fu_valid | fu_ready) & any_ready & ~mispredicted & ~reset;
    assign win_oh       = NUM_RS'(1) << win_idx;
    assign consumed_bus = win_oh & {NUM_RS{load}};

    always_ff @(posedge clk) begin
        if (reset) begin
            fu_valid       <= 1'b0;
            fu_data        <= FU_DATA_RST;
            fu_src         <= 2'd0;
            dispatch_count <= 32'd0;
            for (int i = 0; i < NUM_RS; i++) older[i] <= '0;
        end else if (mispredicted) begin
            fu_valid <= 1'b0;
            for (int i = 0; i < NUM_RS; i++) older[i] <= '0;
        end else begin
            if (alloc) begin
                for (int i = 0; i < NUM_RS; i++) begin
                    if (i != int'(alloc_idx)) older[i][alloc_idx] <= 1'b1;
                    older[alloc_idx][i] <= 1'b0;
                end
            end
            if (load) begin
                fu_valid       <= 1'b1;
                fu_data        <= slot_data[win_idx];
                fu_src         <= win_idx;
                dispatch_count <= dispatch_count + 32'd1;
            end else if (fu_ready) begin
                fu_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs_scheduler.sv
// Bench for rs_scheduler: emulates four reservation stations and checks against an allocation-order queue model.
module tb_rs_scheduler;
    import rs_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mispredicted = 1'b0;
    logic       issue_valid = 1'b0;
    logic       issue_stall = 1'b0;
    logic       fu_ready = 1'b0;
    logic [3:0] busy_bus = 4'b0;
    rs_out_t    rs0_data = '0;
    rs_out_t    rs1_data = '0;
    rs_out_t    rs2_data = '0;
    rs_out_t    rs3_data = '0;
    logic [2:0] rs_dest;
    logic       rs_full;
    logic [3:0] consumed_bus;
    logic       fu_valid;
    rs_out_t    fu_data;
    logic [1:0] fu_src;
    logic [31:0] dispatch_count;

    always #5 clk = ~clk;

    rs_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .mispredicted   (mispredicted),
        .issue_valid    (issue_valid),
        .issue_stall    (issue_stall),
        .busy_bus       (busy_bus),
        .rs0_data       (rs0_data),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .rs3_data       (rs3_data),
        .fu_ready       (fu_ready),
        .rs_dest        (rs_dest),
        .rs_full        (rs_full),
        .consumed_bus   (consumed_bus),
        .fu_valid       (fu_valid),
        .fu_data        (fu_data),
        .fu_src         (fu_src),
        .dispatch_count (dispatch_count)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: RS contents plus the order in which live slots were allocated.
    logic [3:0]  m_busy = 4'b0;
    rs_out_t     m_d [4];
    int          age_q [$];
    logic        m_fv = 1'b0;
    rs_out_t     m_fd = '0;
    logic [1:0]  m_fs = 2'd0;
    logic [31:0] m_cnt = 32'd0;

    logic [2:0] obs_dest;
    logic       obs_full;
    logic [3:0] obs_cons;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rs_out_t rand_entry(input logic vop);
        rs_out_t e;
        e.valid_operands = vop;
        e.ALU_op         = alu_op_t'($urandom_range(0, 9));
        e.ROB_entry      = 6'($urandom);
        e.branch_type    = branch_t'($urandom_range(0, 6));
        e.rs1            = $urandom;
        e.rs2            = $urandom;
        e.load           = 1'($urandom);
        return e;
    endfunction

    task automatic drive();
        busy_bus = m_busy;
        rs0_data = m_d[0];
        rs1_data = m_d[1];
        rs2_data = m_d[2];
        rs3_data = m_d[3];
    endtask

    // One clock: apply inputs, check combinational outputs, clock, update model, check registered outputs.
    task automatic cyc(input logic iv, input logic is, input logic fr, input logic mp, input logic vop_new);
        int         lowest_free;
        int         win;
        logic       ld;
        logic       al;
        logic [3:0] exp_cons;
        logic [2:0] exp_dest;
        rs_out_t    ne;
        lowest_free = -1;
        win         = -1;
        issue_valid  = iv;
        issue_stall  = is;
        fu_ready     = fr;
        mispredicted = mp;
        drive();
        #2;
        for (int i = 3; i >= 0; i--) if (!m_busy[i]) lowest_free = i;
        foreach (age_q[k]) begin
            if (win < 0 && m_busy[age_q[k]] && m_d[age_q[k]].valid_operands) win = age_q[k];
        end
        ld       = (!m_fv || fr) && (win >= 0) && !mp;
        exp_cons = ld ? 4'(1 << win) : 4'b0;
        exp_dest = (mp || lowest_free < 0) ? 3'b100 : 3'(lowest_free);
        al       = iv && !is && (lowest_free >= 0) && !mp;
        chk("rs_dest", 128'(rs_dest), 128'(exp_dest));
        chk("rs_full", 128'(rs_full), 128'(iv && lowest_free < 0));
        chk("consumed_bus", 128'(consumed_bus), 128'(exp_cons));
        obs_dest = rs_dest;
        obs_full = rs_full;
        obs_cons = consumed_bus;
        ne = rand_entry(vop_new);
        @(posedge clk);
        #1;
        if (mp) begin
            m_fv   = 1'b0;
            m_busy = 4'b0;
            age_q.delete();
        end else begin
            if (ld) begin
                m_fd = m_d[win];
                m_fs = 2'(win);
                m_fv = 1'b1;
                m_cnt++;
                m_busy[win] = 1'b0;
                for (int k = 0; k < age_q.size(); k++) begin
                    if (age_q[k] == win) begin
                        age_q.delete(k);
                        break;
                    end
                end
            end else if (fr) begin
                m_fv = 1'b0;
            end
            if (al) begin
                m_busy[lowest_free] = 1'b1;
                m_d[lowest_free]    = ne;
                age_q.push_back(lowest_free);
            end
        end
        chk("fu_valid", 128'(fu_valid), 128'(m_fv));
        if (m_fv) begin
            chk("fu_src", 128'(fu_src), 128'(m_fs));
            chk("fu_data", 128'(fu_data), 128'(m_fd));
        end
        chk("dispatch_count", 128'(dispatch_count), 128'(m_cnt));
        drive();
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        issue_valid  = 1'b1;
        fu_ready     = 1'b1;
        mispredicted = 1'b0;
        drive();
        #2;
        chk("rst_dest", 128'(rs_dest), 128'(3'b100));
        chk("rst_consumed", 128'(consumed_bus), 128'(4'b0));
        @(posedge clk);
        #1;
        m_busy = 4'b0;
        age_q.delete();
        m_fv  = 1'b0;
        m_fd  = '0;
        m_fs  = 2'd0;
        m_cnt = 32'd0;
        drive();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        issue_valid = 1'b0;
        fu_ready    = 1'b0;
        #2;
        chk("rst_fu_valid", 128'(fu_valid), 128'(1'b0));
        chk("rst_fu_data", 128'(fu_data), 128'(0));
        chk("rst_alu_op", 128'(fu_data.ALU_op), 128'(NOP));
        chk("rst_branch", 128'(fu_data.branch_type), 128'(NB));
        chk("rst_fu_src", 128'(fu_src), 128'(2'd0));
        chk("rst_count", 128'(dispatch_count), 128'(32'd0));
        chk("rst_dest_after", 128'(rs_dest), 128'(3'd0));
    endtask

    initial begin
        rs_out_t     t3_entry;
        logic [31:0] cnt0;
        logic [3:0]  exp_c [3];
        logic [1:0]  exp_s [3];
        for (int i = 0; i < 4; i++) m_d[i] = '0;
        drive();
        @(posedge clk);
        #1;
        do_reset();

        // Fill all four slots, fifth request sees NONE_DEST and rs_full.
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t1_dest", 128'(obs_dest), 128'((k < 4) ? k : 4));
        end
        chk("t1_full", 128'(obs_full), 128'(1'b1));

        // Free slots 0 and 1, reallocate them so the age order is 2,3,0,1.
        m_d[0].valid_operands = 1'b1;
        m_d[1].valid_operands = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_pre0", 128'(obs_cons), 128'(4'b0001));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_pre1", 128'(obs_cons), 128'(4'b0010));
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_alloc0", 128'(obs_dest), 128'(3'd0));
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t2_alloc1", 128'(obs_dest), 128'(3'd1));
        m_d[2].valid_operands = 1'b1;
        m_d[0].valid_operands = 1'b1;
        m_d[1].valid_operands = 1'b1;
        exp_c[0] = 4'b0100; exp_c[1] = 4'b0001; exp_c[2] = 4'b0010;
        exp_s[0] = 2'd2;    exp_s[1] = 2'd0;    exp_s[2] = 2'd1;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk("t2_order_cons", 128'(obs_cons), 128'(exp_c[k]));
            chk("t2_order_src", 128'(fu_src), 128'(exp_s[k]));
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Backpressure: slot 0 dispatched then held three cycles while slot 1 waits.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        t3_entry = m_d[0];
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_first", 128'(obs_cons), 128'(4'b0001));
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t3_hold_cons", 128'(obs_cons), 128'(4'b0000));
            chk("t3_hold_valid", 128'(fu_valid), 128'(1'b1));
            chk("t3_hold_data", 128'(fu_data), 128'(t3_entry));
            chk("t3_hold_src", 128'(fu_src), 128'(2'd0));
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t3_release", 128'(obs_cons), 128'(4'b0010));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // CDB wakeup: slot 1 becomes ready the cycle after the broadcast.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_slot", 128'(obs_dest), 128'(3'd1));
        m_d[1].ROB_entry = 6'd9;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_no_bypass", 128'(obs_cons), 128'(4'b0000));
        m_d[1].valid_operands = 1'b1;
        m_d[1].rs1            = 32'hCAFE_0005;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t4_cons", 128'(obs_cons), 128'(4'b0010));
        chk("t4_valid", 128'(fu_valid), 128'(1'b1));
        chk("t4_rs1", 128'(fu_data.rs1), 128'(32'hCAFE_0005));

        // Flush with a valid op in the stage and two ready slots.
        m_d[0].valid_operands = 1'b1;
        m_d[3].valid_operands = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_cons", 128'(obs_cons), 128'(4'b0000));
        chk("t5_dest", 128'(obs_dest), 128'(3'b100));
        chk("t5_valid", 128'(fu_valid), 128'(1'b0));
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t5_realloc", 128'(obs_dest), 128'(k));
        end
        m_d[2].valid_operands = 1'b1;
        m_d[1].valid_operands = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_age1", 128'(obs_cons), 128'(4'b0010));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t5_age2", 128'(obs_cons), 128'(4'b0100));
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Full stations, slot 3 dispatches and is the next allocation target.
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_full", 128'(obs_full), 128'(1'b1));
        m_d[3].valid_operands = 1'b1;
        cnt0 = m_cnt;
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_cons", 128'(obs_cons), 128'(4'b1000));
        chk("t6_count", 128'(dispatch_count), 128'(cnt0 + 32'd1));
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_dest", 128'(obs_dest), 128'(3'd3));
        chk("t6_not_full", 128'(obs_full), 128'(1'b0));

        // Random traffic, a mid-run reset, then more random traffic.
        for (int pass = 0; pass < 2; pass++) begin
            for (int n = 0; n < 400; n++) begin
                for (int i = 0; i < 4; i++) begin
                    if (m_busy[i] && !m_d[i].valid_operands && ($urandom_range(0, 3) == 0)) begin
                        m_d[i].valid_operands = 1'b1;
                        m_d[i].rs1            = $urandom;
                    end
                end
                cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 29) == 0),
                    1'($urandom_range(0, 1)));
            end
            if (pass == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
